// File: rtl/ocp_mem_target_if.sv
// Clock/reset bundle and OCP command/write-data/response bundle for ocp_mem_target.
interface clk_rst_bus;
  logic clk;
  logic rst;

  modport dut (input clk, input rst);
endinterface

interface ocp_mem_target_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [2:0]    MCmd;
  logic [AW-1:0] MAddr;
  logic [2:0]    MTagID;
  logic          SCmdAccept;
  logic [DW-1:0] MData;
  logic          MDataValid;
  logic          SDataAccept;
  logic [1:0]    SResp;
  logic [DW-1:0] SData;
  logic [2:0]    STagID;
  logic          MRespAccept;

  modport master (
    output MCmd, MAddr, MTagID, MData, MDataValid, MRespAccept,
    input  SCmdAccept, SDataAccept, SResp, SData, STagID
  );

  modport slave (
    input  MCmd, MAddr, MTagID, MData, MDataValid, MRespAccept,
    output SCmdAccept, SDataAccept, SResp, SData, STagID
  );
endinterface

// File: rtl/ocp_mem_target.sv
// OCP memory target: queues commands and write data, executes them in order
// against a local word memory and returns read responses with backpressure.
module ocp_mem_target #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RD_LAT    = 2
) (
  clk_rst_bus.dut          clk_rst_if,
  ocp_mem_target_if.slave  ocp,
  output logic [7:0]       err_cnt
);

  localparam int unsigned IW     = AW - 2;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WR    = 3'b001;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_RESP} state_e;

  logic clk;
  logic rst;
  assign clk = clk_rst_if.clk;
  assign rst = clk_rst_if.rst;

  logic [DW-1:0] mem [MEM_DEPTH];

  // Command FIFO: read flag, word index, tag
  logic             cq_rd  [CMD_DEPTH];
  logic [IW-1:0]    cq_idx [CMD_DEPTH];
  logic [2:0]       cq_tag [CMD_DEPTH];
  logic [PTR_W-1:0] cq_wp, cq_rp;
  logic [CNT_W-1:0] cq_cnt, cq_cnt_d;

  logic [DW-1:0]    dq_data [CMD_DEPTH];
  logic [PTR_W-1:0] dq_wp, dq_rp;
  logic [CNT_W-1:0] dq_cnt, dq_cnt_d;

  logic scmd_accept_q, sdata_accept_q;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic              rd_ok_q, rd_ok_d;
  logic [2:0]        rd_tag_q, rd_tag_d;
  logic [1:0]        sresp_q, sresp_d;
  logic [DW-1:0]     sdata_q, sdata_d;
  logic [2:0]        stag_q, stag_d;

  logic cmd_fire_c, cmd_push_c, cmd_illegal_c, data_push_c;
  logic cmd_pop_c, data_pop_c, mem_we_c, exec_err_c;
  logic head_ok_c;
  logic [1:0] err_inc_c;
  logic [8:0] err_sum_c;

  assign cmd_fire_c    = (ocp.MCmd != CMD_IDLE) && scmd_accept_q;
  assign cmd_push_c    = cmd_fire_c && ((ocp.MCmd == CMD_WR) || (ocp.MCmd == CMD_RD));
  assign cmd_illegal_c = cmd_fire_c && !cmd_push_c;
  assign data_push_c   = ocp.MDataValid && sdata_accept_q;

  assign head_ok_c = (cq_idx[cq_rp] < IW'(MEM_DEPTH));
  assign cq_cnt_d  = cq_cnt + CNT_W'(cmd_push_c) - CNT_W'(cmd_pop_c);
  assign dq_cnt_d  = dq_cnt + CNT_W'(data_push_c) - CNT_W'(data_pop_c);

  assign err_inc_c = 2'(cmd_illegal_c) + 2'(exec_err_c);
  assign err_sum_c = 9'(err_cnt) + 9'(err_inc_c);

  // Executor next-state and response datapath
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rd_addr_d  = rd_addr_q;
    rd_ok_d    = rd_ok_q;
    rd_tag_d   = rd_tag_q;
    sresp_d    = sresp_q;
    sdata_d    = sdata_q;
    stag_d     = stag_q;
    cmd_pop_c  = 1'b0;
    data_pop_c = 1'b0;
    mem_we_c   = 1'b0;
    exec_err_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cq_cnt != '0) begin
          if (cq_rd[cq_rp]) begin
            cmd_pop_c = 1'b1;
            lat_d     = LAT_W'(RD_LAT - 1);
            rd_addr_d = cq_idx[cq_rp][MEM_AW-1:0];
            rd_ok_d   = head_ok_c;
            rd_tag_d  = cq_tag[cq_rp];
            state_d   = S_READ_WAIT;
          end else if (dq_cnt != '0) begin
            cmd_pop_c  = 1'b1;
            data_pop_c = 1'b1;
            mem_we_c   = head_ok_c;
            exec_err_c = !head_ok_c;
          end
        end
      end
      S_READ_WAIT: begin
        if (lat_q == '0) begin
          state_d    = S_RESP;
          stag_d     = rd_tag_q;
          sresp_d    = rd_ok_q ? RESP_DVA : RESP_ERR;
          sdata_d    = rd_ok_q ? mem[rd_addr_q] : '0;
          exec_err_c = !rd_ok_q;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (ocp.MRespAccept) begin
          state_d = S_IDLE;
          sresp_d = RESP_NULL;
          sdata_d = '0;
          stag_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lat_q          <= '0;
      rd_addr_q      <= '0;
      rd_ok_q        <= 1'b0;
      rd_tag_q       <= '0;
      sresp_q        <= RESP_NULL;
      sdata_q        <= '0;
      stag_q         <= '0;
      cq_wp          <= '0;
      cq_rp          <= '0;
      cq_cnt         <= '0;
      dq_wp          <= '0;
      dq_rp          <= '0;
      dq_cnt         <= '0;
      scmd_accept_q  <= 1'b0;
      sdata_accept_q <= 1'b0;
      err_cnt        <= '0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      rd_addr_q      <= rd_addr_d;
      rd_ok_q        <= rd_ok_d;
      rd_tag_q       <= rd_tag_d;
      sresp_q        <= sresp_d;
      sdata_q        <= sdata_d;
      stag_q         <= stag_d;
      cq_wp          <= cq_wp + PTR_W'(cmd_push_c);
      cq_rp          <= cq_rp + PTR_W'(cmd_pop_c);
      cq_cnt         <= cq_cnt_d;
      dq_wp          <= dq_wp + PTR_W'(data_push_c);
      dq_rp          <= dq_rp + PTR_W'(data_pop_c);
      dq_cnt         <= dq_cnt_d;
      scmd_accept_q  <= (cq_cnt_d != CNT_W'(CMD_DEPTH));
      sdata_accept_q <= (dq_cnt_d != CNT_W'(CMD_DEPTH));
      err_cnt        <= (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
    end
  end

  // FIFO storage and memory array carry no reset
  always_ff @(posedge clk) begin
    if (cmd_push_c) begin
      cq_rd[cq_wp]  <= (ocp.MCmd == CMD_RD);
      cq_idx[cq_wp] <= ocp.MAddr[AW-1:2];
      cq_tag[cq_wp] <= ocp.MTagID;
    end
    if (data_push_c) begin
      dq_data[dq_wp] <= ocp.MData;
    end
    if (mem_we_c) begin
      mem[cq_idx[cq_rp][MEM_AW-1:0]] <= dq_data[dq_rp];
    end
  end

  assign ocp.SCmdAccept  = scmd_accept_q;
  assign ocp.SDataAccept = sdata_accept_q;
  assign ocp.SResp       = sresp_q;
  assign ocp.SData       = sdata_q;
  assign ocp.STagID      = stag_q;

endmodule

// File: tb/tb_ocp_mem_target.sv
// Bench for ocp_mem_target: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ocp_mem_target;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned CMD_DEPTH = 4;
  localparam int unsigned RD_LAT    = 2;

  clk_rst_bus cr ();
  ocp_mem_target_if #(.AW(AW), .DW(DW)) ocp ();
  logic [7:0] err_cnt;

  ocp_mem_target #(
    .AW(AW), .DW(DW), .MEM_DEPTH(MEM_DEPTH), .CMD_DEPTH(CMD_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_rst_if (cr),
    .ocp        (ocp),
    .err_cnt    (err_cnt)
  );

  initial cr.clk = 1'b0;
  always #5 cr.clk = ~cr.clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: in-order queues, sparse memory, response due-cycle
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [2:0]  tag;
  } mcmd_t;

  mcmd_t       m_cq [$];
  logic [31:0] m_dq [$];
  logic [31:0] m_mem [int];
  int          m_phase;     // 0 idle, 1 waiting for read data, 2 response presented
  longint      m_cyc, m_due;
  mcmd_t       m_cur;
  logic [31:0] m_d;
  int          m_errs;
  bit          m_acc, m_dacc;
  logic [1:0]  exp_resp  = 2'b00;
  logic [31:0] exp_data  = '0;
  logic [2:0]  exp_tag   = '0;
  bit          exp_cacc  = 1'b0;
  bit          exp_dacc  = 1'b0;
  int          exp_err   = 0;

  always @(posedge cr.clk or posedge cr.rst) begin
    if (cr.rst) begin
      m_cq.delete();
      m_dq.delete();
      m_phase  = 0;
      exp_resp = 2'b00;
      exp_data = '0;
      exp_tag  = '0;
      exp_cacc = 1'b0;
      exp_dacc = 1'b0;
      exp_err  = 0;
    end else begin
      m_cyc++;
      m_errs = 0;
      m_acc  = exp_cacc;
      m_dacc = exp_dacc;
      if (m_phase == 0) begin
        if (m_cq.size() > 0) begin
          if (m_cq[0].rd) begin
            m_cur   = m_cq.pop_front();
            m_phase = 1;
            m_due   = m_cyc + RD_LAT;
          end else if (m_dq.size() > 0) begin
            m_cur = m_cq.pop_front();
            m_d   = m_dq.pop_front();
            if ((m_cur.addr >> 2) < MEM_DEPTH) m_mem[int'(m_cur.addr >> 2)] = m_d;
            else m_errs++;
          end
        end
      end else if (m_phase == 1) begin
        if (m_cyc == m_due) begin
          m_phase = 2;
          exp_tag = m_cur.tag;
          if ((m_cur.addr >> 2) < MEM_DEPTH) begin
            exp_resp = 2'b01;
            exp_data = m_mem[int'(m_cur.addr >> 2)];
          end else begin
            exp_resp = 2'b11;
            exp_data = '0;
            m_errs++;
          end
        end
      end else if (ocp.MRespAccept) begin
        m_phase  = 0;
        exp_resp = 2'b00;
        exp_data = '0;
        exp_tag  = '0;
      end
      if (ocp.MCmd != 3'b000 && m_acc) begin
        if (ocp.MCmd == 3'b001 || ocp.MCmd == 3'b010)
          m_cq.push_back('{rd: (ocp.MCmd == 3'b010), addr: ocp.MAddr, tag: ocp.MTagID});
        else
          m_errs++;
      end
      if (ocp.MDataValid && m_dacc) m_dq.push_back(ocp.MData);
      exp_err  = (exp_err + m_errs > 255) ? 255 : exp_err + m_errs;
      exp_cacc = (m_cq.size() < CMD_DEPTH);
      exp_dacc = (m_dq.size() < CMD_DEPTH);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge cr.clk) begin
    check("SResp", 32'(ocp.SResp), 32'(exp_resp));
    check("SData", ocp.SData, exp_data);
    check("STagID", 32'(ocp.STagID), 32'(exp_tag));
    check("SCmdAccept", 32'(ocp.SCmdAccept), 32'(exp_cacc));
    check("SDataAccept", 32'(ocp.SDataAccept), 32'(exp_dacc));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cr.clk);
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [2:0] tag);
    int k;
    @(negedge cr.clk);
    ocp.MCmd   = cmd;
    ocp.MAddr  = addr;
    ocp.MTagID = tag;
    k = 0;
    while (!ocp.SCmdAccept && k < 100) begin
      @(negedge cr.clk);
      k++;
    end
    if (k >= 100) timeout_fail("cmd_accept_wait");
    @(negedge cr.clk);
    ocp.MCmd = 3'b000;
  endtask

  task automatic send_data(input logic [31:0] d);
    int k;
    @(negedge cr.clk);
    ocp.MData      = d;
    ocp.MDataValid = 1'b1;
    k = 0;
    while (!ocp.SDataAccept && k < 100) begin
      @(negedge cr.clk);
      k++;
    end
    if (k >= 100) timeout_fail("data_accept_wait");
    @(negedge cr.clk);
    ocp.MDataValid = 1'b0;
  endtask

  // Returns the number of clock edges from command acceptance to response
  task automatic wait_resp(output int lat);
    int n;
    n = 0;
    while (ocp.SResp == 2'b00 && n < 50) begin
      @(negedge cr.clk);
      n++;
    end
    if (n >= 50) timeout_fail("resp_wait");
    lat = n;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] tag,
                         output logic [1:0] resp, output logic [31:0] data,
                         output logic [2:0] rtag, output int lat);
    send_cmd(3'b010, addr, tag);
    wait_resp(lat);
    resp = ocp.SResp;
    data = ocp.SData;
    rtag = ocp.STagID;
  endtask

  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic [2:0]  r_tag;
  int          r_lat;
  logic [31:0] wr_vals [4];

  initial begin
    cr.rst          = 1'b0;
    ocp.MCmd        = 3'b000;
    ocp.MAddr       = '0;
    ocp.MTagID      = '0;
    ocp.MData       = '0;
    ocp.MDataValid  = 1'b0;
    ocp.MRespAccept = 1'b1;
    #1 cr.rst = 1'b1;
    #2;
    check("rst_SResp", 32'(ocp.SResp), 32'd0);
    check("rst_SCmdAccept", 32'(ocp.SCmdAccept), 32'd0);
    check("rst_SDataAccept", 32'(ocp.SDataAccept), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick(2);
    cr.rst = 1'b0;
    tick(2);
    check("post_rst_SCmdAccept", 32'(ocp.SCmdAccept), 32'd1);

    // Write then read back with latency measurement
    send_data(32'hDEADBEEF);
    send_cmd(3'b001, 32'h10, 3'd1);
    tick(3);
    do_read(32'h10, 3'd2, r_resp, r_data, r_tag, r_lat);
    check("t1_resp", 32'(r_resp), 32'd1);
    check("t1_data", r_data, 32'hDEADBEEF);
    check("t1_tag", 32'(r_tag), 32'd2);
    check("t1_latency", 32'(r_lat), 32'd3);
    tick(3);

    // Fill the command FIFO with writes whose data arrives later
    wr_vals[0] = 32'hA0A0A0A0; wr_vals[1] = 32'hA1A1A1A1;
    wr_vals[2] = 32'hA2A2A2A2; wr_vals[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) send_cmd(3'b001, 32'h20 + 32'(4 * i), 3'(i));
    check("t2_full_SCmdAccept", 32'(ocp.SCmdAccept), 32'd0);
    for (int i = 0; i < 4; i++) send_data(wr_vals[i]);
    tick(4);
    check("t2_SCmdAccept_back", 32'(ocp.SCmdAccept), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_read(32'h20 + 32'(4 * i), 3'(i + 4), r_resp, r_data, r_tag, r_lat);
      check("t2_readback", r_data, wr_vals[i]);
      tick(1);
    end

    // Write data ahead of its command
    send_data(32'h11111111);
    tick(3);
    send_cmd(3'b001, 32'h4, 3'd5);
    tick(2);
    do_read(32'h4, 3'd5, r_resp, r_data, r_tag, r_lat);
    check("t3_data", r_data, 32'h11111111);
    tick(2);

    // Response held under backpressure
    send_data(32'hCAFE0000);
    send_cmd(3'b001, 32'h0, 3'd0);
    tick(2);
    ocp.MRespAccept = 1'b0;
    do_read(32'h0, 3'd6, r_resp, r_data, r_tag, r_lat);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_resp", 32'(ocp.SResp), 32'd1);
      check("t4_hold_data", ocp.SData, 32'hCAFE0000);
      check("t4_hold_tag", 32'(ocp.STagID), 32'd6);
      if (i < 4) tick(1);
    end
    ocp.MRespAccept = 1'b1;
    tick(1);
    check("t4_cleared_resp", 32'(ocp.SResp), 32'd0);
    check("t4_cleared_data", ocp.SData, 32'd0);
    tick(2);

    // Error sources: out-of-range read, illegal command, out-of-range write
    do_read(32'h1000, 3'd3, r_resp, r_data, r_tag, r_lat);
    check("t5_err_resp", 32'(r_resp), 32'd3);
    check("t5_err_data", r_data, 32'd0);
    send_cmd(3'b111, 32'h0, 3'd0);
    send_data(32'h99999999);
    send_cmd(3'b001, 32'h1000, 3'd1);
    tick(3);
    check("t5_err_cnt", 32'(err_cnt), 32'd3);

    // Saturation of the error counter
    @(negedge cr.clk);
    ocp.MCmd = 3'b111;
    tick(260);
    ocp.MCmd = 3'b000;
    tick(2);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);

    // Asynchronous reset while a response is being held
    send_data(32'h600DF00D);
    send_cmd(3'b001, 32'h40, 3'd0);
    tick(2);
    ocp.MRespAccept = 1'b0;
    do_read(32'h40, 3'd1, r_resp, r_data, r_tag, r_lat);
    #1 cr.rst = 1'b1;
    #1;
    check("rst_in_resp_SResp", 32'(ocp.SResp), 32'd0);
    check("rst_in_resp_SData", ocp.SData, 32'd0);
    check("rst_in_resp_err", 32'(err_cnt), 32'd0);
    ocp.MRespAccept = 1'b1;
    tick(2);
    cr.rst = 1'b0;
    tick(2);

    // Asynchronous reset during read latency with two commands queued
    send_cmd(3'b010, 32'h40, 3'd1);
    send_cmd(3'b010, 32'h40, 3'd2);
    send_cmd(3'b001, 32'h44, 3'd3);
    #1 cr.rst = 1'b1;
    #1;
    check("t6_SResp", 32'(ocp.SResp), 32'd0);
    check("t6_SCmdAccept", 32'(ocp.SCmdAccept), 32'd0);
    tick(2);
    cr.rst = 1'b0;
    tick(6);
    check("t6_no_stale_resp", 32'(ocp.SResp), 32'd0);
    do_read(32'h40, 3'd4, r_resp, r_data, r_tag, r_lat);
    check("t6_fresh_data", r_data, 32'h600DF00D);
    check("t6_fresh_tag", 32'(r_tag), 32'd4);
    check("t6_fresh_latency", 32'(r_lat), 32'd3);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
